draw_sequencer: RTL and testbench

- Initiator side of the graphing-unit plot/done handshake.
- On each frame tick, issues a one-cycle plot pulse to each enabled graphing unit in turn. While that unit draws, routes its pixel stream (x, y, colour, writeEn) to the VGA adapter, then waits for its done pulse before moving on.
- Sits between the game controller's frame timer and the graphing units / VGA adapter.

---
 rtl/draw_sequencer.sv | 150 +++++++++++++++
 tb/tb_draw_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer.sv
// draw_sequencer: walks the enabled graphing units once per frame tick,
// handing each a plot pulse, forwarding its pixel stream to the VGA adapter
// and waiting for its done pulse (or a timeout) before moving on.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// IDLE         | no pass running; a frame_tick latches the enable mask
// ISSUE        | one-cycle plot pulse to unit sel; clears the wait counter
// WAIT         | unit sel is drawing; its pixels reach the VGA adapter
// NEXT         | pick the next enabled unit above sel, or finish the pass
// FRAME_DONE   | one-cycle frame_done pulse, then back to IDLE
module draw_sequencer #(
    parameter int N_GU    = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic [N_GU-1:0]     gu_enable,
    input  logic [N_GU-1:0]     gu_done,
    input  logic [9*N_GU-1:0]   gu_x,
    input  logic [8*N_GU-1:0]   gu_y,
    input  logic [3*N_GU-1:0]   gu_colour,
    input  logic [N_GU-1:0]     gu_writeEn,
    output logic [N_GU-1:0]     gu_plot,
    output logic [8:0]          x_out,
    output logic [7:0]          y_out,
    output logic [2:0]          colour_out,
    output logic                writeEn,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun,
    output logic                timeout_err
);

    localparam int SEL_W = (N_GU > 1) ? $clog2(N_GU) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ISSUE      = 3'd1;
    localparam logic [2:0] S_WAIT       = 3'd2;
    localparam logic [2:0] S_NEXT       = 3'd3;
    localparam logic [2:0] S_FRAME_DONE = 3'd4;

    logic [2:0]       state;
    logic [SEL_W-1:0] sel;
    logic [N_GU-1:0]  mask;
    logic [CNT_W-1:0] wait_cnt;

    logic [SEL_W-1:0] first_idx;
    logic             next_found;
    logic [SEL_W-1:0] next_idx;

    // Lowest set bit of the incoming enable mask (valid when the mask is non-zero).
    always_comb begin
        first_idx = '0;
        for (int i = N_GU - 1; i >= 0; i--) begin
            if (gu_enable[i]) begin
                first_idx = SEL_W'(i);
            end
        end
    end

    // Lowest latched-enabled unit strictly above the current selection.
    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        for (int i = N_GU - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(sel))) begin
                next_found = 1'b1;
                next_idx   = SEL_W'(i);
            end
        end
    end

    // Sequencer state, selection, wait timer and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            sel         <= '0;
            mask        <= '0;
            wait_cnt    <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // A tick is only accepted from IDLE; anywhere else it is dropped.
            if (frame_tick && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (frame_tick) begin
                        mask <= gu_enable;
                        if (|gu_enable) begin
                            sel   <= first_idx;
                            state <= S_ISSUE;
                        end else begin
                            state <= S_FRAME_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // Done beats a coincident timeout, so the error flag stays clear.
                    if (gu_done[sel]) begin
                        state <= S_NEXT;
                    end else if (wait_cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_NEXT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (next_found) begin
                        sel   <= next_idx;
                        state <= S_ISSUE;
                    end else begin
                        state <= S_FRAME_DONE;
                    end
                end
                S_FRAME_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Plot pulse, pixel routing from the selected unit and status outputs.
    always_comb begin
        gu_plot = '0;
        if (state == S_ISSUE) begin
            gu_plot[sel] = 1'b1;
        end
        x_out      = gu_x[9*int'(sel) +: 9];
        y_out      = gu_y[8*int'(sel) +: 8];
        colour_out = gu_colour[3*int'(sel) +: 3];
        writeEn    = (state == S_WAIT) ? gu_writeEn[sel] : 1'b0;
        busy       = (state != S_IDLE);
        frame_done = (state == S_FRAME_DONE);
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: two instances (long and short timeout) share all
// stimulus except gu_done, which comes from per-instance graphing-unit
// responders. A pass-level reference model checks every output each cycle;
// a vector table and directed sequences cover the named corner cases.
module tb_draw_sequencer;

    localparam int N    = 4;
    localparam int TO_A = 64;
    localparam int TO_T = 16;

    localparam int PH_PLOT = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_GAP  = 2;
    localparam int PH_END  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, frame_tick;
    logic [3:0]  gu_enable, stray, gu_wen;
    logic [35:0] gu_x;
    logic [31:0] gu_y;
    logic [11:0] gu_colour;
    logic [3:0]  rdone_a = '0, rdone_t = '0;
    logic [3:0]  done_a, done_t;
    assign done_a = rdone_a | stray;
    assign done_t = rdone_t | stray;

    logic [3:0] plot_a, plot_t;
    logic [8:0] x_a, x_t;
    logic [7:0] y_a, y_t;
    logic [2:0] c_a, c_t;
    logic       we_a, we_t, busy_a, busy_t, fd_a, fd_t, ovr_a, ovr_t, terr_a, terr_t;

    draw_sequencer #(.N_GU(N), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .gu_enable(gu_enable),
        .gu_done(done_a), .gu_x(gu_x), .gu_y(gu_y), .gu_colour(gu_colour),
        .gu_writeEn(gu_wen), .gu_plot(plot_a), .x_out(x_a), .y_out(y_a),
        .colour_out(c_a), .writeEn(we_a), .busy(busy_a), .frame_done(fd_a),
        .overrun(ovr_a), .timeout_err(terr_a));

    draw_sequencer #(.N_GU(N), .TIMEOUT(TO_T)) dut_t (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .gu_enable(gu_enable),
        .gu_done(done_t), .gu_x(gu_x), .gu_y(gu_y), .gu_colour(gu_colour),
        .gu_writeEn(gu_wen), .gu_plot(plot_t), .x_out(x_t), .y_out(y_t),
        .colour_out(c_t), .writeEn(we_t), .busy(busy_t), .frame_done(fd_t),
        .overrun(ovr_t), .timeout_err(terr_t));

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Graphing-unit responders: done returns dly cycles after the plot cycle (0 = never).
    int dly_a[4], dly_t[4], rc_a[4], rc_t[4];
    bit arm_a[4], arm_t[4];
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) arm_a[i] = 0;
            else if (plot_a[i] && dly_a[i] > 0) begin arm_a[i] = 1; rc_a[i] = dly_a[i]; end
            else if (arm_a[i]) begin if (rc_a[i] == 0) arm_a[i] = 0; else rc_a[i]--; end
            rdone_a[i] = arm_a[i] && (rc_a[i] == 0);
            if (reset) arm_t[i] = 0;
            else if (plot_t[i] && dly_t[i] > 0) begin arm_t[i] = 1; rc_t[i] = dly_t[i]; end
            else if (arm_t[i]) begin if (rc_t[i] == 0) arm_t[i] = 0; else rc_t[i]--; end
            rdone_t[i] = arm_t[i] && (rc_t[i] == 0);
        end
    end

    // Reference model: a pass is the ascending list of enabled units, each
    // visited as plot cycle, wait cycles, one gap cycle; then one done cycle.
    int m_lim[2] = '{TO_A, TO_T};
    bit m_busy[2], m_ovr[2], m_terr[2];
    int m_phase[2], m_cur[2], m_cnt[2], m_len[2], m_pos[2];
    int m_list[2][8];
    logic [3:0] m_dn;
    int done3_cyc = -100;

    always @(posedge clk) begin
        if (done_a[3]) done3_cyc = cyc;
        for (int k = 0; k < 2; k++) begin
            m_dn = (k == 0) ? done_a : done_t;
            if (reset) begin
                m_busy[k] = 0; m_ovr[k] = 0; m_terr[k] = 0; m_cur[k] = 0;
            end else if (!m_busy[k]) begin
                if (frame_tick) begin
                    m_len[k] = 0;
                    for (int u = 0; u < 4; u++)
                        if (gu_enable[u]) begin m_list[k][m_len[k]] = u; m_len[k]++; end
                    m_busy[k] = 1;
                    m_pos[k] = 0;
                    if (m_len[k] == 0) m_phase[k] = PH_END;
                    else begin m_cur[k] = m_list[k][0]; m_phase[k] = PH_PLOT; end
                end
            end else begin
                if (frame_tick) m_ovr[k] = 1;
                case (m_phase[k])
                    PH_PLOT: begin m_phase[k] = PH_WAIT; m_cnt[k] = 0; end
                    PH_WAIT: begin
                        m_cnt[k]++;
                        if (m_dn[m_cur[k]]) m_phase[k] = PH_GAP;
                        else if (m_cnt[k] == m_lim[k]) begin m_terr[k] = 1; m_phase[k] = PH_GAP; end
                    end
                    PH_GAP: begin
                        m_pos[k]++;
                        if (m_pos[k] < m_len[k]) begin m_cur[k] = m_list[k][m_pos[k]]; m_phase[k] = PH_PLOT; end
                        else m_phase[k] = PH_END;
                    end
                    default: m_busy[k] = 0;
                endcase
            end
        end
        cyc++;
    end

    // Per-cycle comparison of both instances against the model, plus pass logs for instance A.
    logic [3:0] ep;
    logic       ewe;
    string      pf;
    int plog[$];
    int fdlog[$];
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                pf = (k == 0) ? "a" : "t";
                ep = '0;
                if (m_busy[k] && m_phase[k] == PH_PLOT) ep[m_cur[k]] = 1'b1;
                ewe = m_busy[k] && (m_phase[k] == PH_WAIT) && gu_wen[m_cur[k]];
                check({pf, ".plot"},  (k == 0) ? plot_a : plot_t, ep);
                check({pf, ".busy"},  (k == 0) ? busy_a : busy_t, m_busy[k]);
                check({pf, ".fdone"}, (k == 0) ? fd_a : fd_t, m_busy[k] && m_phase[k] == PH_END);
                check({pf, ".we"},    (k == 0) ? we_a : we_t, ewe);
                check({pf, ".x"},     (k == 0) ? x_a : x_t, gu_x[m_cur[k]*9 +: 9]);
                check({pf, ".y"},     (k == 0) ? y_a : y_t, gu_y[m_cur[k]*8 +: 8]);
                check({pf, ".col"},   (k == 0) ? c_a : c_t, gu_colour[m_cur[k]*3 +: 3]);
                check({pf, ".ovr"},   (k == 0) ? ovr_a : ovr_t, m_ovr[k]);
                check({pf, ".terr"},  (k == 0) ? terr_a : terr_t, m_terr[k]);
            end
            for (int u = 0; u < 4; u++) if (plot_a[u]) plog.push_back(u);
            if (fd_a) fdlog.push_back(cyc);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick(input logic [3:0] en);
        gu_enable  = en;
        frame_tick = 1'b1;
        next_cycle();
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic wait_fd(input int which, input int maxc, input string nm);
        int  n    = 0;
        bit  seen = 0;
        n_checks++;
        while (!seen && n < maxc) begin
            @(negedge clk);
            if (((which == 0) ? fd_a : fd_t) === 1'b1) seen = 1;
            n++;
        end
        if (!seen) begin
            n_errors++;
            $display("FAIL %s: no frame_done within %0d cycles", nm, maxc);
        end
        next_cycle();
    endtask

    task automatic wait_plot_a(input logic [3:0] want, input int maxc, input string nm);
        int n    = 0;
        bit seen = 0;
        n_checks++;
        while (!seen && n < maxc) begin
            @(negedge clk);
            if (plot_a === want) seen = 1;
            n++;
        end
        if (!seen) begin
            n_errors++;
            $display("FAIL %s: plot %0h not seen within %0d cycles", nm, want, maxc);
        end
    endtask

    typedef struct {
        bit         rst;
        bit         tick;
        logic [3:0] en;
        logic [3:0] dn;
        logic [3:0] e_plot;
        bit         e_busy;
        bit         e_fd;
        bit         e_ovr;
    } vec_t;

    vec_t vt[15];
    int   exp_ord[3];
    int   n;
    logic [3:0] en_r;

    initial begin
        // rst tick en dn | plot busy fdone overrun  (outputs seen in the same cycle)
        vt[0]  = '{1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0};
        vt[1]  = '{0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0};
        vt[2]  = '{0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0};
        vt[3]  = '{0, 1, 4'b0110, 4'b0000, 4'b0000, 0, 0, 0};
        vt[4]  = '{0, 0, 4'b0110, 4'b0010, 4'b0010, 1, 0, 0};
        vt[5]  = '{0, 0, 4'b0110, 4'b0100, 4'b0000, 1, 0, 0};
        vt[6]  = '{0, 0, 4'b0110, 4'b0010, 4'b0000, 1, 0, 0};
        vt[7]  = '{0, 0, 4'b0110, 4'b0000, 4'b0000, 1, 0, 0};
        vt[8]  = '{0, 0, 4'b0110, 4'b0100, 4'b0100, 1, 0, 0};
        vt[9]  = '{0, 0, 4'b0110, 4'b0100, 4'b0000, 1, 0, 0};
        vt[10] = '{0, 0, 4'b0110, 4'b0000, 4'b0000, 1, 0, 0};
        vt[11] = '{0, 1, 4'b1111, 4'b0000, 4'b0000, 1, 1, 0};
        vt[12] = '{0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1};
        vt[13] = '{1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1};
        vt[14] = '{0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0};

        reset = 1'b1; frame_tick = 1'b0; gu_enable = '0; stray = '0;
        gu_x = '0; gu_y = '0; gu_colour = '0; gu_wen = '0;
        for (int i = 0; i < 4; i++) begin dly_a[i] = 0; dly_t[i] = 0; end
        next_cycle();
        chk_en = 1;
        next_cycle();

        // Vector table: empty mask, two-unit pass with stray/early dones, tick during FRAME_DONE.
        for (int i = 0; i < 15; i++) begin
            reset = vt[i].rst; frame_tick = vt[i].tick; gu_enable = vt[i].en; stray = vt[i].dn;
            @(negedge clk);
            check($sformatf("vec%0d.plot", i), plot_a, vt[i].e_plot);
            check($sformatf("vec%0d.busy", i), busy_a, vt[i].e_busy);
            check($sformatf("vec%0d.fdone", i), fd_a, vt[i].e_fd);
            check($sformatf("vec%0d.ovr", i), ovr_a, vt[i].e_ovr);
            next_cycle();
        end
        reset = 1'b0; frame_tick = 1'b0; stray = '0;

        // Mask 1011, every unit answers 20 cycles after its plot.
        for (int i = 0; i < 4; i++) begin dly_a[i] = 20; dly_t[i] = 20; end
        plog.delete(); fdlog.delete();
        pulse_tick(4'b1011);
        wait_fd(0, 200, "s1.wait_fd");
        repeat (3) next_cycle();
        exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 3;
        check("s1.nplot", plog.size(), 3);
        for (int i = 0; i < 3; i++) if (i < plog.size()) check("s1.order", plog[i], exp_ord[i]);
        check("s1.nfd", fdlog.size(), 1);
        // done seen at the end of cycle d: NEXT in d+1, FRAME_DONE in d+2
        if (fdlog.size() > 0) check("s1.fd_lat", fdlog[0] - done3_cyc, 2);

        // Pixel routing: unit 1 selected, unit 0 also asserting writeEn.
        do_reset();
        for (int i = 0; i < 4; i++) begin dly_a[i] = 0; dly_t[i] = 0; end
        gu_x = '0; gu_x[17:9] = 9'd10; gu_x[8:0] = 9'd300;
        gu_y = '0; gu_y[15:8] = 8'd50; gu_y[7:0] = 8'd20;
        gu_colour = '0; gu_colour[5:3] = 3'b111; gu_colour[2:0] = 3'b010;
        gu_wen = 4'b0011;
        pulse_tick(4'b0010);
        @(negedge clk);
        check("s2.issue_plot", plot_a, 4'b0010);
        check("s2.issue_we", we_a, 1'b0);
        check("s2.issue_x", x_a, 9'd10);
        next_cycle();
        @(negedge clk);
        check("s2.wait_we", we_a, 1'b1);
        check("s2.wait_x", x_a, 9'd10);
        check("s2.wait_y", y_a, 8'd50);
        check("s2.wait_col", c_a, 3'b111);
        next_cycle();
        stray = 4'b0010;
        next_cycle();
        stray = '0;
        @(negedge clk);
        check("s2.next_we", we_a, 1'b0);
        check("s2.next_busy", busy_a, 1'b1);
        next_cycle();
        @(negedge clk);
        check("s2.fd", fd_a, 1'b1);
        next_cycle();

        // Unit 0 never answers: short-timeout instance gives up after 16 WAIT cycles.
        do_reset();
        gu_wen = '0;
        dly_a[0] = 0; dly_t[0] = 0;
        for (int i = 1; i < 4; i++) begin dly_a[i] = 5; dly_t[i] = 5; end
        pulse_tick(4'b0011);
        next_cycle();
        for (int w = 1; w <= 16; w++) begin
            @(negedge clk);
            check($sformatf("s3.terr_wait%0d", w), terr_t, 1'b0);
            next_cycle();
        end
        @(negedge clk);
        check("s3.terr_set", terr_t, 1'b1);
        check("s3.next_plot", plot_t, 4'b0000);
        next_cycle();
        @(negedge clk);
        check("s3.plot_u1", plot_t, 4'b0010);
        check("s3.a_waiting", plot_a, 4'b0000);
        wait_fd(1, 40, "s3.t_fd");
        wait_fd(0, 120, "s3.a_fd");
        for (int i = 0; i < 4; i++) begin dly_a[i] = 3; dly_t[i] = 3; end
        pulse_tick(4'b0011);
        wait_fd(0, 40, "s3.pass2_fd");
        check("s3.terr_sticky_t", terr_t, 1'b1);
        check("s3.terr_sticky_a", terr_a, 1'b1);

        // Tick mid-pass plus unit 2's done pulsed while unit 0 is selected.
        do_reset();
        for (int i = 0; i < 4; i++) begin dly_a[i] = 8; dly_t[i] = 8; end
        plog.delete(); fdlog.delete();
        pulse_tick(4'b0111);
        next_cycle();
        stray = 4'b0100; frame_tick = 1'b1; gu_enable = 4'b1000;
        next_cycle();
        stray = '0; frame_tick = 1'b0;
        @(negedge clk);
        check("s4.ovr", ovr_a, 1'b1);
        next_cycle();
        wait_fd(0, 100, "s4.fd");
        exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 2;
        check("s4.nplot", plog.size(), 3);
        for (int i = 0; i < 3; i++) if (i < plog.size()) check("s4.order", plog[i], exp_ord[i]);
        check("s4.ovr_sticky", ovr_a, 1'b1);

        // Reset while waiting on unit 2, with a tick in the reset cycle.
        do_reset();
        dly_a[0] = 4; dly_a[1] = 4; dly_a[2] = 0; dly_a[3] = 0;
        dly_t[0] = 4; dly_t[1] = 4; dly_t[2] = 0; dly_t[3] = 0;
        gu_wen = 4'b1111;
        pulse_tick(4'b0111);
        wait_plot_a(4'b0100, 40, "s5.reach_u2");
        next_cycle();
        next_cycle();
        reset = 1'b1; frame_tick = 1'b1;
        next_cycle();
        reset = 1'b0; frame_tick = 1'b0;
        @(negedge clk);
        check("s5.plot", plot_a, 4'b0000);
        check("s5.busy", busy_a, 1'b0);
        check("s5.fd", fd_a, 1'b0);
        check("s5.we", we_a, 1'b0);
        check("s5.ovr", ovr_a, 1'b0);
        check("s5.terr", terr_t, 1'b0);
        next_cycle();
        dly_a[2] = 4; dly_t[2] = 4;
        pulse_tick(4'b0111);
        @(negedge clk);
        check("s5.restart", plot_a, 4'b0001);
        next_cycle();
        wait_fd(0, 60, "s5.fd_after");

        // Randomized passes, checked cycle by cycle against the model.
        do_reset();
        for (int it = 0; it < 40; it++) begin
            en_r = 4'($urandom());
            for (int i = 0; i < 4; i++) begin
                dly_a[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 24));
                dly_t[i] = dly_a[i];
            end
            pulse_tick(en_r);
            n = 0;
            while ((busy_a || busy_t) && n < 400) begin
                gu_x = 36'({$urandom(), $urandom()});
                gu_y = $urandom();
                gu_colour = 12'($urandom());
                gu_wen = 4'($urandom());
                stray = ($urandom_range(0, 15) == 0) ? 4'($urandom()) : 4'd0;
                frame_tick = ($urandom_range(0, 30) == 0);
                reset = ($urandom_range(0, 299) == 0);
                next_cycle();
                n++;
            end
            reset = 1'b0; frame_tick = 1'b0; stray = '0;
            n_checks++;
            if (n >= 400) begin
                n_errors++;
                $display("FAIL rnd%0d.idle: still busy after %0d cycles", it, n);
            end
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
